// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned WORD_LENGTH      = 32;
    localparam int unsigned DMEM_MAX_LATENCY = 7;
    localparam int unsigned DMEM_CNT_W       = 3;

    typedef enum logic {ARB_IDLE, ARB_WAIT} dmem_arb_state_t;
    typedef enum logic {REQ_P, REQ_D} dmem_req_id_t;

    // Value loaded into the WAIT down-counter at the read-grant edge.
    function automatic logic [DMEM_CNT_W-1:0] dmem_cnt_init(input int unsigned latency);
        return DMEM_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; the last-grant history lives in the caller.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last,  // 1 = requester 1 was granted most recently
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = req0 & (~req1 | last);
        gnt1 = req1 & (~req0 | ~last);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataMemory between the pipeline MEM stage (P) and the
// debug/loader port (D); sequences fixed-latency reads and generates p_stall.
module dmem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned WORD_LENGTH = dmem_arbiter_pkg::WORD_LENGTH
) (
    input  logic                   CLK,
    input  logic                   Reset,

    input  logic                   p_req,
    input  logic                   p_we,
    input  logic [2:0]             p_funct3,
    input  logic [WORD_LENGTH-1:0] p_addr,
    input  logic [WORD_LENGTH-1:0] p_wdata,
    output logic                   p_gnt,
    output logic                   p_rvalid,
    output logic [WORD_LENGTH-1:0] p_rdata,
    output logic                   p_stall,

    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [2:0]             d_funct3,
    input  logic [WORD_LENGTH-1:0] d_addr,
    input  logic [WORD_LENGTH-1:0] d_wdata,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [WORD_LENGTH-1:0] d_rdata,

    output logic                   m_en,
    output logic                   m_we,
    output logic [2:0]             m_funct3,
    output logic [WORD_LENGTH-1:0] m_addr,
    output logic [WORD_LENGTH-1:0] m_wdata,
    input  logic [WORD_LENGTH-1:0] m_rdata
);

    import dmem_arbiter_pkg::*;

    if (MEM_LATENCY < 1 || MEM_LATENCY > DMEM_MAX_LATENCY) begin : g_bad_latency
        $error("dmem_arbiter: MEM_LATENCY out of range 1..7");
    end

    localparam logic [DMEM_CNT_W-1:0] CNT_INIT = dmem_cnt_init(MEM_LATENCY);

    dmem_arb_state_t        state_q, state_d;
    dmem_req_id_t           last_gnt_q, last_gnt_d;
    dmem_req_id_t           owner_q, owner_d;
    logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   p_pending_q, p_pending_d;
    logic                   d_pending_q, d_pending_d;
    logic                   p_rvalid_q, p_rvalid_d;
    logic                   d_rvalid_q, d_rvalid_d;
    logic [WORD_LENGTH-1:0] p_rdata_q, p_rdata_d;
    logic [WORD_LENGTH-1:0] d_rdata_q, d_rdata_d;

    logic idle;
    logic arb_req_p;
    logic arb_req_d;
    logic arb_last;
    logic arb_gnt_p;
    logic arb_gnt_d;

    // Requests are only visible to the arbiter in IDLE, so no grant can leak into WAIT.
    always_comb begin
        idle      = (state_q == ARB_IDLE);
        arb_req_p = p_req & idle;
        arb_req_d = d_req & idle;
        arb_last  = (last_gnt_q == REQ_D);
    end

    rr_arbiter2 u_rr_arbiter2 (
        .req0 (arb_req_p),
        .req1 (arb_req_d),
        .last (arb_last),
        .gnt0 (arb_gnt_p),
        .gnt1 (arb_gnt_d)
    );

    always_comb begin
        p_gnt    = arb_gnt_p;
        d_gnt    = arb_gnt_d;
        m_en     = arb_gnt_p | arb_gnt_d;
        m_we     = 1'b0;
        m_funct3 = '0;
        m_addr   = '0;
        m_wdata  = '0;
        if (arb_gnt_p) begin
            m_we     = p_we;
            m_funct3 = p_funct3;
            m_addr   = p_addr;
            m_wdata  = p_wdata;
        end else if (arb_gnt_d) begin
            m_we     = d_we;
            m_funct3 = d_funct3;
            m_addr   = d_addr;
            m_wdata  = d_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        p_pending_d = p_pending_q;
        d_pending_d = d_pending_q;
        p_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        p_rdata_d   = p_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (m_en) begin
                    last_gnt_d = arb_gnt_p ? REQ_P : REQ_D;
                    if (!m_we) begin
                        owner_d = last_gnt_d;
                        cnt_d   = CNT_INIT;
                        state_d = ARB_WAIT;
                        if (arb_gnt_p) begin
                            p_pending_d = 1'b1;
                        end else begin
                            d_pending_d = 1'b1;
                        end
                    end
                end
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                    if (owner_q == REQ_P) begin
                        p_rdata_d   = m_rdata;
                        p_rvalid_d  = 1'b1;
                        p_pending_d = 1'b0;
                    end else begin
                        d_rdata_d   = m_rdata;
                        d_rvalid_d  = 1'b1;
                        d_pending_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ARB_IDLE;
            last_gnt_q  <= REQ_D;
            owner_q     <= REQ_P;
            cnt_q       <= '0;
            p_pending_q <= 1'b0;
            d_pending_q <= 1'b0;
            p_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            p_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            p_pending_q <= p_pending_d;
            d_pending_q <= d_pending_d;
            p_rvalid_q  <= p_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            p_rdata_q   <= p_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        p_rvalid = p_rvalid_q;
        d_rvalid = d_rvalid_q;
        p_rdata  = p_rdata_q;
        d_rdata  = d_rdata_q;
        p_stall  = (p_req & ~arb_gnt_p) | p_pending_q;
    end

    a_one_grant : assert property (@(posedge CLK) disable iff (Reset) !(p_gnt && d_gnt));
    a_no_en_in_wait : assert property (@(posedge CLK) disable iff (Reset)
                                       !(m_en && state_q == ARB_WAIT));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: three arbiters (MEM_LATENCY 1, 2, 3) share stimulus, each with its own memory.
module tb_dmem_arbiter;

    localparam int L1 = 0;
    localparam int L2 = 1;
    localparam int L3 = 2;

    logic        CLK;
    logic        Reset;
    logic        p_req, p_we, d_req, d_we;
    logic [2:0]  p_funct3, d_funct3;
    logic [31:0] p_addr, p_wdata, d_addr, d_wdata;

    logic [2:0]  p_gnt_v, p_rvalid_v, p_stall_v, d_gnt_v, d_rvalid_v, m_en_v, m_we_v;
    logic [2:0]  m_funct3_v [3];
    logic [31:0] p_rdata_v [3];
    logic [31:0] d_rdata_v [3];
    logic [31:0] m_addr_v [3];
    logic [31:0] m_wdata_v [3];
    logic [31:0] m_rdata_v [3];

    int n_checks;
    int n_errors;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem [16];
        logic [3:0]  raddr;

        dmem_arbiter #(
            .MEM_LATENCY (g + 1),
            .WORD_LENGTH (32)
        ) u_dut (
            .CLK      (CLK),
            .Reset    (Reset),
            .p_req    (p_req),
            .p_we     (p_we),
            .p_funct3 (p_funct3),
            .p_addr   (p_addr),
            .p_wdata  (p_wdata),
            .p_gnt    (p_gnt_v[g]),
            .p_rvalid (p_rvalid_v[g]),
            .p_rdata  (p_rdata_v[g]),
            .p_stall  (p_stall_v[g]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_funct3 (d_funct3),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_gnt    (d_gnt_v[g]),
            .d_rvalid (d_rvalid_v[g]),
            .d_rdata  (d_rdata_v[g]),
            .m_en     (m_en_v[g]),
            .m_we     (m_we_v[g]),
            .m_funct3 (m_funct3_v[g]),
            .m_addr   (m_addr_v[g]),
            .m_wdata  (m_wdata_v[g]),
            .m_rdata  (m_rdata_v[g])
        );

        // Read data stays on the bus from the cycle after issue until the next read.
        always @(posedge CLK) begin
            if (m_en_v[g] && m_we_v[g]) mem[m_addr_v[g][5:2]] <= m_wdata_v[g];
            if (m_en_v[g] && !m_we_v[g]) raddr <= m_addr_v[g][5:2];
        end
        assign m_rdata_v[g] = mem[raddr];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        p_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        p_we = 0; d_we = 0; p_funct3 = 0; d_funct3 = 0;
        p_addr = 0; p_wdata = 0; d_addr = 0; d_wdata = 0;
        do_reset();

        // Reset state
        #1;
        check("rst_p_gnt", {29'd0, p_gnt_v}, 32'd0);
        check("rst_p_rvalid", {29'd0, p_rvalid_v}, 32'd0);
        check("rst_d_rvalid", {29'd0, d_rvalid_v}, 32'd0);
        check("rst_p_stall", {29'd0, p_stall_v}, 32'd0);
        check("rst_m_en", {29'd0, m_en_v}, 32'd0);
        check("rst_p_rdata", p_rdata_v[L3], 32'd0);
        check("rst_d_rdata", d_rdata_v[L3], 32'd0);

        // 1: P store, same-cycle grant and memory strobe
        p_req = 1; p_we = 1; p_funct3 = 3'b010; p_addr = 32'h10; p_wdata = 32'hDEADBEEF;
        #1;
        check("t1_p_gnt", p_gnt_v[L1], 1);
        check("t1_d_gnt", d_gnt_v[L1], 0);
        check("t1_m_en", m_en_v[L1], 1);
        check("t1_m_we", m_we_v[L1], 1);
        check("t1_m_addr", m_addr_v[L1], 32'h10);
        check("t1_m_wdata", m_wdata_v[L1], 32'hDEADBEEF);
        check("t1_m_funct3", {29'd0, m_funct3_v[L1]}, 32'd2);
        check("t1_p_stall", p_stall_v[L1], 0);
        tick();
        p_req = 0;

        // 2: P load of 0x10; latency 3 (and latency 1 alongside)
        p_req = 1; p_we = 0; p_addr = 32'h10;
        #1;
        check("t2_p_gnt", p_gnt_v[L3], 1);
        check("t2_m_we", m_we_v[L3], 0);
        check("t2_stall_T", p_stall_v[L3], 0);
        tick();
        p_req = 0;
        #1;
        check("t2_stall_T1", p_stall_v[L3], 1);
        check("t2_l1_stall_T1", p_stall_v[L1], 1);
        check("t2_m_en_wait", m_en_v[L3], 0);
        tick(); #1;
        check("t2_stall_T2", p_stall_v[L3], 1);
        check("t2_l1_rvalid", p_rvalid_v[L1], 1);
        check("t2_l1_rdata", p_rdata_v[L1], 32'hDEADBEEF);
        check("t2_l1_stall_T2", p_stall_v[L1], 0);
        tick(); #1;
        check("t2_stall_T3", p_stall_v[L3], 1);
        check("t2_rvalid_T3", p_rvalid_v[L3], 0);
        tick(); #1;
        check("t2_rvalid_T4", p_rvalid_v[L3], 1);
        check("t2_rdata_T4", p_rdata_v[L3], 32'hDEADBEEF);
        check("t2_stall_T4", p_stall_v[L3], 0);
        tick(); #1;
        check("t2_rvalid_T5", p_rvalid_v[L3], 0);
        check("t2_rdata_hold", p_rdata_v[L3], 32'hDEADBEEF);

        // 3: both ports write continuously; P first, then alternating
        do_reset();
        p_req = 1; p_we = 1; p_funct3 = 3'b010; p_addr = 32'h20; p_wdata = 32'h12345678;
        d_req = 1; d_we = 1; d_funct3 = 3'b000; d_addr = 32'h24; d_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_p_gnt", p_gnt_v[L1], (i % 2 == 0) ? 1 : 0);
            check("t3_d_gnt", d_gnt_v[L1], (i % 2 == 0) ? 0 : 1);
            check("t3_m_addr", m_addr_v[L1], (i % 2 == 0) ? 32'h20 : 32'h24);
            check("t3_m_funct3", {29'd0, m_funct3_v[L1]}, (i % 2 == 0) ? 32'd2 : 32'd0);
            tick();
        end
        idle_inputs();

        // 4: D read outstanding (latency 2) blocks a P read
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h24;
        #1;
        check("t4_d_gnt", d_gnt_v[L2], 1);
        tick();
        d_req = 0;
        p_req = 1; p_we = 0; p_addr = 32'h20;
        #1;
        check("t4_p_gnt_T1", p_gnt_v[L2], 0);
        check("t4_stall_T1", p_stall_v[L2], 1);
        tick(); #1;
        check("t4_p_gnt_T2", p_gnt_v[L2], 0);
        check("t4_stall_T2", p_stall_v[L2], 1);
        tick(); #1;
        check("t4_d_rvalid_T3", d_rvalid_v[L2], 1);
        check("t4_d_rdata_T3", d_rdata_v[L2], 32'hCAFEF00D);
        check("t4_p_gnt_T3", p_gnt_v[L2], 1);
        check("t4_stall_T3", p_stall_v[L2], 0);
        tick();
        p_req = 0;
        #1;
        check("t4_stall_T4", p_stall_v[L2], 1);
        tick(); #1;
        check("t4_stall_T5", p_stall_v[L2], 1);
        check("t4_rvalid_T5", p_rvalid_v[L2], 0);
        tick(); #1;
        check("t4_rvalid_T6", p_rvalid_v[L2], 1);
        check("t4_rdata_T6", p_rdata_v[L2], 32'h12345678);

        // 5: reset during the WAIT of a second P read (latency 3)
        do_reset();
        p_req = 1; p_we = 0; p_addr = 32'h10;
        #1;
        check("t5_p_gnt_T", p_gnt_v[L3], 1);
        tick();
        p_req = 0;
        tick();
        tick();
        tick();
        p_req = 1;
        #1;
        check("t5_rvalid_T4", p_rvalid_v[L3], 1);
        check("t5_rdata_T4", p_rdata_v[L3], 32'hDEADBEEF);
        check("t5_regrant_T4", p_gnt_v[L3], 1);
        tick();
        p_req = 0;
        Reset = 1;
        tick();
        Reset = 0;
        #1;
        check("t5_rvalid_after_rst", p_rvalid_v[L3], 0);
        check("t5_rdata_after_rst", p_rdata_v[L3], 32'd0);
        check("t5_stall_after_rst", p_stall_v[L3], 0);
        check("t5_m_en_after_rst", m_en_v[L3], 0);
        p_req = 1; p_we = 1; p_addr = 32'h30;
        d_req = 1; d_we = 1; d_addr = 32'h34;
        #1;
        check("t5_p_prio", p_gnt_v[L3], 1);
        check("t5_d_blocked", d_gnt_v[L3], 0);
        check("t5_stall_gnt", p_stall_v[L3], 0);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_no_rvalid", p_rvalid_v[L3], 0);
            tick();
        end

        // 6: D pulses a request while a P read is outstanding, then gives up
        p_req = 1; p_we = 0; p_addr = 32'h10;
        #1;
        check("t6_p_gnt", p_gnt_v[L3], 1);
        tick();
        p_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h24;
        #1;
        check("t6_d_gnt_T1", d_gnt_v[L3], 0);
        check("t6_m_en_T1", m_en_v[L3], 0);
        tick();
        d_req = 0;
        for (int i = 2; i < 6; i++) begin
            #1;
            check("t6_d_gnt", d_gnt_v[L3], 0);
            check("t6_m_en", m_en_v[L3], 0);
            check("t6_d_rvalid", d_rvalid_v[L3], 0);
            check("t6_p_rvalid", p_rvalid_v[L3], (i == 4) ? 1 : 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
